// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : two-flop synchronizer plus debounce FSM for a push-button;
//                yields a clean level, press/release pulses and a long-press pulse
// Revision     : 1.0
// ============================================================================
module btn_debounce #(
    parameter  int DB_CYCLES   = 2_000_000,
    parameter  int LONG_CYCLES = 100_000_000,
    localparam int CNT_W       = $clog2(LONG_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    logic             sync_s1_q;
    logic             sync_s2_q;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic             long_done_q, long_done_d;
    logic             level_q,     level_d;
    logic             press_q,     press_d;
    logic             release_q,   release_d;
    logic             long_q,      long_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1_q <= 1'b0;
            sync_s2_q <= 1'b0;
        end else begin
            sync_s1_q <= btn_raw;
            sync_s2_q <= sync_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync_s2_q) begin
                    state_d  = ST_ARMING;
                    db_cnt_d = '0;
                end
            end

            ST_ARMING: begin
                if (!sync_s2_q) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == C_DB_LAST) begin
                    state_d     = ST_PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + C_ONE;
                end
            end

            ST_PRESSED: begin
                // Saturate so a button held indefinitely can never re-trigger long_pulse.
                if (hold_cnt_q != C_LONG_MAX) begin
                    hold_cnt_d = hold_cnt_q + C_ONE;
                end
                if ((hold_cnt_q == C_LONG_LAST) && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!sync_s2_q) begin
                    state_d  = ST_RELEASING;
                    db_cnt_d = '0;
                end
            end

            ST_RELEASING: begin
                if (sync_s2_q) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == C_DB_LAST) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + C_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// tb_btn_debounce : randomized and directed bench for btn_debounce against a
//                   run-length behavioural model
// Revision        : 1.0
// ============================================================================
module tb_btn_debounce;

    localparam int DB   = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    int checks = 0;
    int errors = 0;

    btn_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    // Model: the accepted level flips once DB+1 consecutive synchronized samples
    // disagree with it; hold time accrues only while accepted with no disagreement.
    bit m_s1 = 0, m_s2 = 0, m_level = 0, m_long_done = 0;
    int m_cnt = 0, m_hold = 0;
    bit exp_press = 0, exp_release = 0, exp_long = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_long_done = 0;
            m_cnt = 0; m_hold = 0;
            exp_press = 0; exp_release = 0; exp_long = 0;
        end else begin
            exp_press = 0; exp_release = 0; exp_long = 0;
            if (m_level && m_cnt == 0) begin
                if (m_hold == LONG - 1 && !m_long_done) begin
                    exp_long = 1;
                    m_long_done = 1;
                end
                m_hold++;
            end
            if (m_s2 != m_level) begin
                m_cnt++;
                if (m_cnt == DB + 1) begin
                    m_level = !m_level;
                    m_cnt = 0;
                    if (m_level) begin
                        exp_press = 1;
                        m_hold = 0;
                        m_long_done = 0;
                    end else begin
                        exp_release = 1;
                    end
                end
            end else begin
                m_cnt = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("btn_level",     int'(btn_level),     int'(m_level));
        check("press_pulse",   int'(press_pulse),   int'(exp_press));
        check("release_pulse", int'(release_pulse), int'(exp_release));
        check("long_pulse",    int'(long_pulse),    int'(exp_long));
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch(input int n, output int np, output int nr, output int nl, output int nhi);
        np = 0; nr = 0; nl = 0; nhi = 0;
        repeat (n) begin
            @(negedge clk);
            np  += int'(press_pulse);
            nr  += int'(release_pulse);
            nl  += int'(long_pulse);
            nhi += int'(btn_level);
        end
    endtask

    initial begin
        int np, nr, nl, nhi;
        int run;

        wait_neg(3);
        check("reset_level", int'(btn_level), 0);
        check("reset_press", int'(press_pulse), 0);
        #2 rst_n = 1'b1;
        wait_neg(3);

        // Clean press: E0 is the posedge right after this drive.
        btn_raw = 1'b1;
        watch(6, np, nr, nl, nhi);
        check("clean_early_press", np, 0);
        wait_neg(1);
        check("clean_press_lit", int'(press_pulse), 1);
        check("clean_level_lit", int'(btn_level), 1);
        check("model_press_lit", int'(exp_press), 1);
        wait_neg(1);
        check("clean_press_low", int'(press_pulse), 0);

        // Long press: long_pulse exactly 20 cycles after press_pulse, only once.
        watch(18, np, nr, nl, nhi);
        check("long_early", nl + nr, 0);
        wait_neg(1);
        check("long_lit", int'(long_pulse), 1);
        check("model_long_lit", int'(exp_long), 1);
        watch(40, np, nr, nl, nhi);
        check("long_second", nl, 0);
        check("long_level_held", nhi, 40);

        // Release bounce then final release.
        btn_raw = 1'b0;
        wait_neg(2);
        btn_raw = 1'b1;
        wait_neg(3);
        btn_raw = 1'b0;
        watch(6, np, nr, nl, nhi);
        check("relbounce_level", nhi, 6);
        check("relbounce_early", nr, 0);
        wait_neg(1);
        check("release_lit", int'(release_pulse), 1);
        check("release_level_lit", int'(btn_level), 0);
        check("model_release_lit", int'(exp_release), 1);
        wait_neg(4);

        // Short tap.
        btn_raw = 1'b1;
        wait_neg(3);
        btn_raw = 1'b0;
        watch(15, np, nr, nl, nhi);
        check("tap_pulses", np + nr + nl, 0);
        check("tap_level", nhi, 0);

        // Press bounce.
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0);
            wait_neg(2);
        end
        btn_raw = 1'b0;
        watch(20, np, nr, nl, nhi);
        check("pbounce_pulses", np + nr + nl, 0);
        check("pbounce_level", nhi, 0);

        // Reset while pressed and held.
        btn_raw = 1'b1;
        wait_neg(10);
        check("rst_pre_level", int'(btn_level), 1);
        #2 rst_n = 1'b0;
        wait_neg(1);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(press_pulse), 0);
        check("rst_release", int'(release_pulse), 0);
        check("rst_long", int'(long_pulse), 0);
        wait_neg(1);
        #2 rst_n = 1'b1;
        watch(6, np, nr, nl, nhi);
        check("rst_early_press", np, 0);
        check("rst_no_release", nr, 0);
        wait_neg(1);
        check("rst_repress_lit", int'(press_pulse), 1);
        btn_raw = 1'b0;
        wait_neg(12);

        // Randomized runs, occasionally long holds and a mid-run reset.
        for (int k = 0; k < 300; k++) begin
            btn_raw = ~btn_raw;
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 35) : $urandom_range(1, 8);
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                wait_neg($urandom_range(1, 3));
                #2 rst_n = 1'b1;
            end
            wait_neg(run);
        end
        btn_raw = 1'b0;
        wait_neg(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the raw push-button input of the traffic-light controller before it reaches that controller's start_btn input. The raw pin is asynchronous and bounces, so this block synchronizes it and debounces both edges with a timed state machine. It outputs a clean level, single-cycle press and release pulses, and a single-cycle long-press pulse. btn_level or press_pulse drives the controller's start_btn; long_pulse is spare for a future mode select.

Parameters:
DB_CYCLES, 2_000_000, consecutive stable synchronized samples needed to accept an edge (20 ms at 100 MHz); must be >= 1
LONG_CYCLES, 100_000_000, cycles of accepted press before long_pulse fires (1 s at 100 MHz); must be > DB_CYCLES
CNT_W, $clog2(LONG_CYCLES+1), width of both counters (derived, not overridden)

Ports:
clk  input  1  100 MHz system clock
rst_n  input  1  asynchronous active-low reset: 0 = reset, 1 = normal operation
btn_raw  input  1  raw asynchronous push-button, active high
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on accepted press
release_pulse  output  1  one-cycle pulse on accepted release
long_pulse  output  1  one-cycle pulse when an accepted press has been held LONG_CYCLES cycles

Behaviour:
- Reset (async assert, sync deassert by use):
  - outputs: all four = 0.
  - internals: sync flops = 0, state = IDLE, db_cnt = 0, hold_cnt = 0, long_done = 0.
- Synchronizer: two flops, btn_raw -> s1 -> s2. The FSM sees only s2.
- All outputs are registered.
- FSM states: IDLE, ARMING, PRESSED, RELEASING.
- IDLE (btn_level = 0):
  - s2 = 1 -> ARMING, db_cnt <= 0.
- ARMING:
  - s2 = 0 -> IDLE (bounce rejected, no pulse).
  - Else if db_cnt == DB_CYCLES-1 -> PRESSED; btn_level <= 1, press_pulse <= 1, hold_cnt <= 0, long_done <= 0.
  - Else db_cnt++.
- PRESSED:
  - hold_cnt increments each cycle, saturating at LONG_CYCLES.
  - When hold_cnt == LONG_CYCLES-1 and long_done == 0: long_pulse <= 1, long_done <= 1. Fires at most once per accepted press.
  - s2 = 0 -> RELEASING, db_cnt <= 0. The hold_cnt increment still applies that cycle.
- RELEASING (btn_level stays 1):
  - s2 = 1 -> PRESSED (bounce rejected, no pulse). hold_cnt and long_done are kept, not cleared.
  - Else if db_cnt == DB_CYCLES-1 -> IDLE; btn_level <= 0, release_pulse <= 1.
  - Else db_cnt++.
  - hold_cnt is frozen in RELEASING.
- Pulses: press_pulse, release_pulse and long_pulse are high for exactly one cycle, then return to 0.
- Latency: let E0 be the first clock edge at which btn_raw = 1 is captured into s1, with btn_raw held stable after that.
  - btn_level and press_pulse go high after edge E0+DB_CYCLES+2.
  - press_pulse goes low after E0+DB_CYCLES+3.
  - Release timing is symmetric.
- Bounce rule: any s2 glitch shorter than DB_CYCLES samples in ARMING or RELEASING aborts that transition and restarts the count on the next qualifying edge.
- Simultaneous events: long_pulse and release_pulse can never fire in the same cycle. long_pulse is generated only in PRESSED; release_pulse only on the RELEASING -> IDLE exit.
- Reset mid-operation: all state is cleared immediately. If the button is still held after deassert, a full DB_CYCLES debounce runs and a fresh press_pulse is produced. No release_pulse is emitted for the press that was aborted.
- Counter arithmetic is unsigned at CNT_W bits. The saturation check guarantees hold_cnt never wraps.

Test Plan:
(Bench parameters: DB_CYCLES = 4, LONG_CYCLES = 20.)
- Clean press: reset, then hold btn_raw = 1 from edge E0. Required: press_pulse = 1 only in the cycle after E0+6; btn_level = 1 from then on; release_pulse and long_pulse stay 0 until cycle 20 of the hold.
- Press bounce: btn_raw toggles 1,0,1,0 every 2 cycles, then stays 0. Required: no pulses; btn_level stays 0; FSM ends in IDLE.
- Long press: hold btn_raw = 1 for 40 cycles after acceptance. Required: exactly one long_pulse, 20 cycles after press_pulse; no second long_pulse while held.
- Release bounce then release: from PRESSED, drop btn_raw for 2 cycles, raise for 3, then drop permanently. Required:
  - btn_level stays 1 through the bounce;
  - one release_pulse, DB_CYCLES+2 edges after the final drop is captured;
  - btn_level = 0 after it.
- Short tap: btn_raw = 1 for 3 cycles only. Required: no press_pulse and no release_pulse.
- Reset mid-press: assert rst_n = 0 while in PRESSED with btn_raw = 1, release reset 2 cycles later. Required:
  - all outputs = 0 during reset;
  - a new press_pulse after a full debounce;
  - no release_pulse emitted.
